// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: RV32I width codes, FSM states, port ids.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, RMW} state_t;

  typedef enum logic {P0 = 1'b0, P1 = 1'b1} port_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane logic: load extraction/extension, store merge, access error flag.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [15:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merged,
  output logic        err
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = mem_rd >> {off, 3'b000};
    load_data = '0;
    err       = 1'b0;
    case (funct3)
      F3_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU: load_data = {24'h000000, shifted[7:0]};
      F3_H: begin
        load_data = {{16{shifted[15]}}, shifted[15:0]};
        err       = off[0];
      end
      F3_HU: begin
        load_data = {16'h0000, shifted[15:0]};
        err       = off[0];
      end
      F3_W: begin
        load_data = mem_rd;
        err       = |off;
      end
      default: err = 1'b1;
    endcase
  end

  // funct3[0] separates half from byte for the two legal sub-word store codes
  always_comb begin
    merged = mem_rd;
    if (funct3[0])
      merged[{off[1], 4'b0000} +: 16] = wdata;
    else
      merged[{off, 3'b000} +: 8] = wdata[7:0];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for two requesters onto a word-only data memory, with
// sub-word loads and read-modify-write sub-word stores.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int RESET_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [2:0]        m0_funct3,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_rerr,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [2:0]        m1_funct3,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_rerr,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  state_t            state;
  port_t             ptr, sel, rmw_port;
  logic [ADDR_W-1:0] rmw_addr;
  logic [31:0]       rmw_data;

  logic              accept, word_store, sub_store;
  logic              s_we;
  logic [2:0]        s_f3;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata, rsp_data;
  logic [31:0]       load_data, merged;
  logic              err;

  dmem_lane_unit u_lane (
    .mem_rd    (mem_rd),
    .wdata     (s_wdata[15:0]),
    .off       (s_addr[1:0]),
    .funct3    (s_f3),
    .load_data (load_data),
    .merged    (merged),
    .err       (err)
  );

  always_comb begin
    if (m0_req && m1_req) sel = ptr;
    else if (m1_req)      sel = P1;
    else                  sel = P0;

    s_we    = (sel == P1) ? m1_we     : m0_we;
    s_f3    = (sel == P1) ? m1_funct3 : m0_funct3;
    s_addr  = (sel == P1) ? m1_addr   : m0_addr;
    s_wdata = (sel == P1) ? m1_wdata  : m0_wdata;

    accept     = reset && (state == IDLE) && (m0_req || m1_req);
    word_store = s_we && !err && (s_f3 == F3_W);
    sub_store  = s_we && !err && (s_f3 != F3_W);
    rsp_data   = (err || s_we) ? '0 : load_data;

    m0_gnt = accept && (sel == P0);
    m1_gnt = accept && (sel == P1);

    // Memory outputs are forced quiet while reset is asserted, even mid-RMW
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    if (reset && (state == RMW)) begin
      mem_a  = rmw_addr;
      mem_wd = rmw_data;
      mem_we = 1'b1;
    end else if (accept) begin
      mem_a = s_addr;
      if (word_store) begin
        mem_wd = s_wdata;
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= (RESET_PRIO != 0) ? P1 : P0;
      rmw_port  <= P0;
      rmw_addr  <= '0;
      rmw_data  <= '0;
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m0_rerr   <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_rerr   <= 1'b0;
    end else begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m0_rerr   <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_rerr   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ptr <= (sel == P0) ? P1 : P0;
            if (sub_store) begin
              state    <= RMW;
              rmw_port <= sel;
              rmw_addr <= s_addr;
              rmw_data <= merged;
            end else if (sel == P0) begin
              m0_rvalid <= 1'b1;
              m0_rdata  <= rsp_data;
              m0_rerr   <= err;
            end else begin
              m1_rvalid <= 1'b1;
              m1_rdata  <= rsp_data;
              m1_rerr   <= err;
            end
          end
        end
        RMW: begin
          state <= IDLE;
          if (rmw_port == P0) m0_rvalid <= 1'b1;
          else                m1_rvalid <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sits between two requesters and the single-port, word-organised data memory.
  - Port m0 is the core load/store unit.
  - Port m1 is the debug/DMA loader.
- Arbitrates the two ports round-robin.
- Performs RV32I sub-word access: byte/half load extraction with sign/zero extension, and byte/half stores as a two-cycle read-modify-write, because the memory only writes full words.
- Returns a registered response per port.

Parameters:
- ADDR_W, 32: width of request and memory addresses.
- RESET_PRIO, 0: port favoured by the round-robin pointer after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- m0_req  in  1  m0 request valid; fields held stable until m0_gnt
- m0_we  in  1  1=store, 0=load
- m0_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  32  store data, right-aligned
- m0_gnt  out  1  request accepted this cycle
- m0_rvalid  out  1  one-cycle completion pulse
- m0_rdata  out  32  load result, extended; 0 for stores and errors
- m0_rerr  out  1  with rvalid: misaligned or illegal funct3
- m1_req, m1_we, m1_funct3, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_rerr: identical set for port m1
- mem_a  out  ADDR_W  memory byte address; memory uses bits [ADDR_W-1:2]
- mem_wd  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_rd  in  32  memory read data, combinational from mem_a

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; priority pointer=RESET_PRIO.
  - All gnt/rvalid/rerr=0; rdata=0; mem_we=0; mem_a=0; mem_wd=0.
  - An in-flight RMW is aborted with no write and no rvalid.
- State IDLE:
  - Grant goes to the single requester, or on contention to the port named by the pointer.
  - gnt is combinational and asserted in the accept cycle only.
  - After each grant, the pointer moves to the other port.
- Error check in the accept cycle:
  - Error if the access is misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0), or
  - if funct3 is 011, 110 or 111.
  - On error: mem_we=0; next cycle rvalid=1, rerr=1, rdata=0.
- Load, accept cycle: mem_a=addr, mem_we=0.
  - Next cycle: rvalid=1, rdata = mem_rd shifted right by addr[1:0]*8, then sign-extended (B, H) or zero-extended (BU, HU, W).
  - Load latency is 1 cycle.
- Word store, accept cycle: mem_a=addr, mem_wd=wdata, mem_we=1.
  - Next cycle: rvalid=1, rdata=0.
- Byte/half store:
  - Accept cycle: mem_a=addr, mem_we=0.
  - The merged word is registered: mem_rd with byte lane addr[1:0] (B) or half lane addr[1] (H) replaced by wdata low bits. Address is registered too.
  - state goes to RMW.
  - RMW cycle: mem_a=held addr, mem_wd=merged, mem_we=1, no grants; state goes to IDLE.
  - The following cycle: rvalid=1, rdata=0.
  - A request may be granted in the same cycle as rvalid.
- Throughput:
  - One access per cycle in IDLE.
  - Sub-word stores occupy 2 cycles.
  - A pending requester waits, with its fields held, across the RMW cycle.
- Idle outputs: with no request and not in RMW, mem_a=0, mem_wd=0, mem_we=0.
- Exclusivity: rvalid is only on the port granted in the preceding completion step; never on both ports in one cycle.
- Addressing: no range check; address wrap is handled by the memory's index truncation.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State encoding IDLE/RMW.
  - Port-select constants P0/P1.
- Sub-module dmem_lane_unit, purely combinational:
  - load_extract(mem_rd, addr[1:0], funct3).
  - store_merge(mem_rd, wdata, addr[1:0], funct3).
  - misalign/illegal flag.
- The arbiter FSM and response registers stay in dmem_arbiter.

Test Plan:
- Word store then load: m0 SW 0xDEADBEEF @0x10, then LW @0x10 -> mem_we=1 in the accept cycle; the load's rdata=0xDEADBEEF one cycle after gnt; rerr=0.
- Sub-word RMW: word @0x20 = 0x11223344; m0 SB 0xAA @0x21 -> 2 busy cycles, memory becomes 0x1122AA44. Then LB @0x21 returns 0xFFFFFFAA and LBU @0x21 returns 0x000000AA.
- Half store/load: SH 0x8001 @0x22 over 0x11223344 -> 0x80013344; LH @0x22 returns 0xFFFF8001; LHU @0x22 returns 0x00008001.
- Contention: both ports request continuously for 4 cycles after reset -> grants m0, m1, m0, m1. During an m0 SB RMW, m1 gnt=0 and m1 is granted in the next IDLE cycle.
- Errors:
  - LW @0x13 -> rvalid, rerr=1, rdata=0, no mem_we.
  - SH @0x05 -> no write.
  - funct3=011 -> rerr=1.
- Reset mid-RMW: assert reset during the RMW cycle of SB @0x21 -> mem_we=0, the word is unchanged, no rvalid, pointer=RESET_PRIO.
